// File: rtl/result_unload.sv
// result_unload: serializes one wide result vector from the compute array
// into a stream of WORD_WIDTH-bit words, least-significant word first.
// A new vector is accepted on the same cycle that the final word of the
// previous one is taken, so back-to-back vectors stream with no bubble.
module result_unload #(
  parameter int      WORD_WIDTH = 32,
  parameter int      NUM_WORDS  = 8,
  localparam int     IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int     VEC_W      = WORD_WIDTH * NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VEC_W-1:0]      result_i,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  last_o,
  output logic [IDX_W-1:0]      word_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;
  logic [VEC_W-1:0]        vec_q,   vec_d;

  logic                    sending;
  logic                    out_hs;
  logic                    capture;

  // State, word counter and held vector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the wide data register is cleared too so that a reset leaves
      // the datapath in a known, all-zero state rather than holding stale data.
      vec_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  // Output decode, handshakes and next-state computation.
  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no
    // path through this block leaves a signal unassigned (no latches).
    state_d        = state_q;
    idx_d          = idx_q;
    vec_d          = vec_q;
    sending        = (state_q == SEND);
    data_valid_o   = 1'b0;
    last_o         = 1'b0;
    data_o         = '0;
    word_idx_o     = '0;
    out_hs         = 1'b0;
    result_ready_o = 1'b0;
    capture        = 1'b0;

    if (sending) begin
      data_valid_o = 1'b1;
      last_o       = (idx_q == LAST_IDX);
      data_o       = vec_q[int'(idx_q) * WORD_WIDTH +: WORD_WIDTH];
      word_idx_o   = idx_q;
    end

    out_hs         = data_valid_o && data_ready_i;
    // Ready while idle, or when the final word leaves this very cycle.
    result_ready_o = !sending || (out_hs && last_o);
    capture        = result_valid_i && result_ready_o;

    if (out_hs) begin
      if (last_o) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + 1'b1;
      end
    end

    // A capture overrides the end-of-vector transition to IDLE.
    if (capture) begin
      vec_d   = result_i;
      idx_d   = '0;
      state_d = SEND;
    end
  end

endmodule

// File: tb/tb_result_unload.sv
// Directed self-checking bench for result_unload (WORD_WIDTH=32, NUM_WORDS=8).
// Inputs are driven on the falling edge and outputs checked 1 ns later.
module tb_result_unload;

  localparam int WW = 32;
  localparam int NW = 8;

  logic            clk;
  logic            rst;
  logic [WW*NW-1:0] result_i;
  logic            result_valid_i;
  logic            result_ready_o;
  logic [WW-1:0]   data_o;
  logic            data_valid_o;
  logic            data_ready_i;
  logic            last_o;
  logic [2:0]      word_idx_o;

  int n_total;
  int n_pass;
  int hs;
  int pat;

  result_unload #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .last_o         (last_o),
    .word_idx_o     (word_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector whose word k holds base + k.
  function automatic logic [WW*NW-1:0] mk_vec(input logic [WW-1:0] base);
    logic [WW*NW-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*WW +: WW] = base + WW'(k);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(data_valid_o), 32'd0);
    check({tag, "_ready"}, 32'(result_ready_o), 32'd1);
    check({tag, "_data"},  data_o, 32'd0);
    check({tag, "_last"},  32'(last_o), 32'd0);
    check({tag, "_idx"},   32'(word_idx_o), 32'd0);
  endtask

  task automatic check_word(input string tag, input logic [31:0] exp_data,
                            input int exp_idx, input logic exp_ready);
    check({tag, "_valid"}, 32'(data_valid_o), 32'd1);
    check({tag, "_data"},  data_o, exp_data);
    check({tag, "_idx"},   32'(word_idx_o), 32'(exp_idx));
    check({tag, "_last"},  32'(last_o), 32'(exp_idx == NW - 1));
    check({tag, "_ready"}, 32'(result_ready_o), 32'(exp_ready));
  endtask

  initial begin
    n_total        = 0;
    n_pass         = 0;
    rst            = 1'b1;
    result_i       = '0;
    result_valid_i = 1'b0;
    data_ready_i   = 1'b0;
    repeat (2) tick();

    // Reset state
    rst = 1'b0;
    #1 check_idle("reset");

    // Single vector, words 0..7, no backpressure
    tick();
    result_i = mk_vec(32'h0); result_valid_i = 1'b1; data_ready_i = 1'b1;
    #1 check("single_ready_idle", 32'(result_ready_o), 32'd1);
    tick();
    result_valid_i = 1'b0; result_i = '0;
    for (int k = 0; k < NW; k++) begin
      #1 check_word("single", 32'(k), k, k == NW - 1);
      tick();
    end
    #1 check_idle("single_done");

    // Backpressure with ready pattern 1,0,0,1,0,0...
    tick();
    result_i = mk_vec(32'hA0); result_valid_i = 1'b1; data_ready_i = 1'b0;
    tick();
    result_valid_i = 1'b0;
    hs = 0; pat = 0;
    for (int cyc = 0; cyc < 40 && hs < NW; cyc++) begin
      data_ready_i = (pat % 3 == 0);
      #1 check_word("bp", 32'hA0 + 32'(hs), hs, data_ready_i && (hs == NW - 1));
      if (data_ready_i) hs++;
      pat++;
      tick();
    end
    check("bp_handshakes", 32'(hs), 32'(NW));
    data_ready_i = 1'b1;
    #1 check_idle("bp_done");

    // Back-to-back vectors A then B, valid held high
    tick();
    result_i = mk_vec(32'hA0); result_valid_i = 1'b1; data_ready_i = 1'b1;
    tick();
    result_i = mk_vec(32'hB0);
    for (int n = 0; n < 2 * NW; n++) begin
      if (n == NW) result_valid_i = 1'b0;
      #1 check_word("b2b", (n < NW) ? 32'hA0 + 32'(n) : 32'hB0 + 32'(n - NW),
                    n % NW, (n % NW) == NW - 1);
      tick();
    end
    #1 check_idle("b2b_done");

    // Busy upstream ignored, then stall on last word with valid pending
    tick();
    result_i = mk_vec(32'hC0); result_valid_i = 1'b1; data_ready_i = 1'b1;
    tick();
    for (int n = 0; n < NW - 1; n++) begin
      result_i = mk_vec(32'h5000 + 32'(n * 16));
      #1 check_word("busy", 32'hC0 + 32'(n), n, 1'b0);
      tick();
    end
    result_i = mk_vec(32'hD0); data_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1 check_word("stall_last", 32'hC7, NW - 1, 1'b0);
      tick();
    end
    data_ready_i = 1'b1;
    #1 check_word("release_last", 32'hC7, NW - 1, 1'b1);
    tick();
    result_valid_i = 1'b0;
    for (int n = 0; n < NW; n++) begin
      #1 check_word("after_stall", 32'hD0 + 32'(n), n, n == NW - 1);
      tick();
    end
    #1 check_idle("stall_done");

    // Reset after word 3 handshake
    tick();
    result_i = mk_vec(32'hE0); result_valid_i = 1'b1; data_ready_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1 check_word("pre_rst", 32'hE0 + 32'(n), n, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check_idle("mid_rst");
    result_i = mk_vec(32'h90); result_valid_i = 1'b1;
    tick();
    result_valid_i = 1'b0;
    for (int n = 0; n < NW; n++) begin
      #1 check_word("post_rst", 32'h90 + 32'(n), n, n == NW - 1);
      tick();
    end
    #1 check_idle("post_rst_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
